// File: rtl/shift_cmd_sequencer.sv
// Moore command sequencer for a load/rotate/arithmetic-shift register.
// Accepts one command in IDLE, then drives the register pins for the required number of cycles.
module shift_cmd_sequencer #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [WIDTH-1:0] cmd_data,
   output logic             sr_en,
   output logic             ParallelLoadn,
   output logic             RotateRight,
   output logic             ASRight,
   output logic [WIDTH-1:0] sr_data,
   output logic             busy,
   output logic             done
);
   localparam int LW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [LW-1:0]    MAX_ASR_STEPS = LW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] ASR_CLAMP     = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_LOAD  = 2'b01,
      ST_SHIFT = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ROTL = 2'b01,
      OP_ROTR = 2'b10,
      OP_ASR  = 2'b11
   } op_t;

   state_t           state_r, state_nxt_s;
   op_t              op_r, op_nxt_s, op_in_s;
   logic [LW-1:0]    cnt_r, cnt_nxt_s, eff_cnt_s;
   logic [WIDTH-1:0] data_nxt_s;
   logic             ready_nxt_s, busy_nxt_s, done_nxt_s, en_nxt_s;
   logic             pln_nxt_s, rr_nxt_s, asr_nxt_s;

   assign op_in_s = op_t'(cmd_op);

   // Effective step count: rotates wrap modulo WIDTH, ASR saturates since extra steps are idempotent.
   always_comb begin
      eff_cnt_s = cmd_count[LW-1:0];
      if ((op_in_s == OP_ASR) && (cmd_count >= ASR_CLAMP)) begin
         eff_cnt_s = MAX_ASR_STEPS;
      end else begin
         eff_cnt_s = cmd_count[LW-1:0];
      end
   end

   // Next state, latched command fields and step counter.
   always_comb begin
      state_nxt_s = state_r;
      op_nxt_s    = op_r;
      cnt_nxt_s   = cnt_r;
      data_nxt_s  = sr_data;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid) begin
               op_nxt_s = op_in_s;
               if (op_in_s == OP_LOAD) begin
                  data_nxt_s  = cmd_data;
                  cnt_nxt_s   = LW'(1'b0);
                  state_nxt_s = ST_LOAD;
               end else if (eff_cnt_s != LW'(1'b0)) begin
                  cnt_nxt_s   = eff_cnt_s;
                  state_nxt_s = ST_SHIFT;
               end else begin
                  cnt_nxt_s   = LW'(1'b0);
                  state_nxt_s = ST_DONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: state_nxt_s = ST_DONE;
         ST_SHIFT: begin
            cnt_nxt_s = cnt_r - LW'(1'b1);
            if (cnt_r == LW'(1'b1)) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state so registered outputs line up with the state register.
   always_comb begin
      ready_nxt_s = 1'b0;
      busy_nxt_s  = 1'b1;
      done_nxt_s  = 1'b0;
      en_nxt_s    = 1'b0;
      pln_nxt_s   = 1'b1;
      rr_nxt_s    = 1'b1;
      asr_nxt_s   = 1'b1;
      case (state_nxt_s)
         ST_IDLE: begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
         end
         ST_LOAD: begin
            en_nxt_s  = 1'b1;
            pln_nxt_s = 1'b0;
         end
         ST_SHIFT: begin
            en_nxt_s  = 1'b1;
            rr_nxt_s  = (op_nxt_s != OP_ROTL);
            asr_nxt_s = (op_nxt_s != OP_ROTR);
         end
         ST_DONE: done_nxt_s = 1'b1;
         default: begin
            ready_nxt_s = 1'b1;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   // State, command and output registers; reset forces sr_en low immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         op_r          <= OP_LOAD;
         cnt_r         <= LW'(1'b0);
         sr_data       <= WIDTH'(1'b0);
         cmd_ready     <= 1'b1;
         busy          <= 1'b0;
         done          <= 1'b0;
         sr_en         <= 1'b0;
         ParallelLoadn <= 1'b1;
         RotateRight   <= 1'b1;
         ASRight       <= 1'b1;
      end else begin
         state_r       <= state_nxt_s;
         op_r          <= op_nxt_s;
         cnt_r         <= cnt_nxt_s;
         sr_data       <= data_nxt_s;
         cmd_ready     <= ready_nxt_s;
         busy          <= busy_nxt_s;
         done          <= done_nxt_s;
         sr_en         <= en_nxt_s;
         ParallelLoadn <= pln_nxt_s;
         RotateRight   <= rr_nxt_s;
         ASRight       <= asr_nxt_s;
      end
   end
endmodule
